// File: rtl/trig_mon.sv
// trig_mon: trigger edge monitor with timestamp FIFO, saturating edge count and sticky alarm/overflow.
// Optional macro TRIG_MON_SYNC_EN adds a two-flop input synchronizer ahead of edge detection.
module trig_mon #(
   parameter int TS_W  = 16,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trigger,
   input  logic            clr,
   input  logic            rd_ready,
   output logic            evt_valid,
   output logic [TS_W-1:0] evt_time,
   output logic [7:0]      evt_count,
   output logic            alarm,
   output logic            overflow
);
   localparam int AW = $clog2(DEPTH);
   logic [TS_W-1:0] cnt;
   logic [TS_W-1:0] mem [DEPTH];
   logic [AW:0]     wp, rp;
   logic            trig_s, trig_q, edge_det, empty, full, push, pop, wr;
`ifdef TRIG_MON_SYNC_EN
   logic [1:0] sync;
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else sync <= {sync[0], trigger};
   assign trig_s = sync[1];
`else
   assign trig_s = trigger;
`endif
   always_comb begin
      empty     = wp == rp;
      full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
      edge_det  = trig_s & ~trig_q;
      push      = edge_det & ~clr;
      pop       = ~empty & rd_ready & ~clr;
      wr        = push & (~full | pop);
      evt_valid = ~empty;
      evt_time  = empty ? '0 : mem[rp[AW-1:0]];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt       <= '0;
         trig_q    <= 1'b0;
         wp        <= '0;
         rp        <= '0;
         evt_count <= '0;
         alarm     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         cnt    <= cnt + 1'b1;
         trig_q <= trig_s;
         if (clr) begin
            wp        <= '0;
            rp        <= '0;
            evt_count <= '0;
            alarm     <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (edge_det && evt_count != 8'hFF) evt_count <= evt_count + 1'b1;
            if (edge_det) alarm <= 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
         end
      end
   // storage needs no reset: entries are only visible behind the pointers
   always_ff @(posedge clk)
      if (wr) mem[wp[AW-1:0]] <= cnt;
endmodule

// File: tb/tb_trig_mon.sv
// tb_trig_mon: scoreboard bench for trig_mon (default build; TRIG_MON_SYNC_EN shifts edge timing by 2).
module tb_trig_mon;
   localparam int DEPTH = 4;
`ifdef TRIG_MON_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   logic clk = 0, rst = 1, trigger = 0, clr = 0, rd_ready = 0;
   logic evt_valid, alarm, overflow, w_valid, w_alarm, w_overflow;
   logic [15:0] evt_time;
   logic [3:0]  w_time;
   logic [7:0]  evt_count, w_count;
   logic [15:0] q[$];
   int m_cnt = 0, cyc = 0, errs = 0, checks = 0;
   logic m_alarm = 0, m_ovf = 0;
   wire [26:0] dut_vec = {evt_valid, evt_time, evt_count, alarm, overflow};

   trig_mon #(.TS_W(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .clr(clr), .rd_ready(rd_ready),
      .evt_valid(evt_valid), .evt_time(evt_time), .evt_count(evt_count),
      .alarm(alarm), .overflow(overflow));
   trig_mon #(.TS_W(4), .DEPTH(DEPTH)) u_w (
      .clk(clk), .rst(rst), .trigger(trigger), .clr(clr), .rd_ready(rd_ready),
      .evt_valid(w_valid), .evt_time(w_time), .evt_count(w_count),
      .alarm(w_alarm), .overflow(w_overflow));

   always #5 clk = ~clk;

   function automatic logic [26:0] model_vec();
      return {q.size() != 0, q.size() != 0 ? q[0] : 16'h0, m_cnt[7:0], m_alarm, m_ovf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_clear();
      q.delete();
      m_cnt = 0;
      m_alarm = 0;
      m_ovf = 0;
   endtask

   // one edge detected in the cycle where rd_ready/clr are applied
   task automatic do_edge(input logic rdy, input logic c);
      logic p, f;
      trigger = 1;
      for (int i = 0; i < LAT; i++) begin
         tick();
         trigger = 0;
      end
      rd_ready = rdy;
      clr = c;
      if (c) model_clear();
      else begin
         p = rdy && q.size() > 0;
         f = q.size() == DEPTH;
         if (p) void'(q.pop_front());
         if (!f || p) q.push_back(16'(cyc)); else m_ovf = 1;
         if (m_cnt < 255) m_cnt++;
         m_alarm = 1;
      end
      tick();
      trigger = 0;
      rd_ready = 0;
      clr = 0;
   endtask

   task automatic pop_one();
      rd_ready = 1;
      if (q.size() > 0) void'(q.pop_front());
      tick();
      rd_ready = 0;
   endtask

   task automatic clear_all();
      clr = 1;
      model_clear();
      tick();
      clr = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut_vec !== 27'h0) begin errs++; $display("FAIL reset: got %h exp 0", dut_vec); end
      rst = 0;
      cyc = 0;
   endtask

   task automatic test_single();
      while (cyc < 5) tick();
      trigger = 1;
      repeat (LAT) tick();
      q.push_back(16'(cyc));
      m_cnt = 1;
      m_alarm = 1;
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL single_edge: got %h exp %h", dut_vec, model_vec()); end
      repeat (6) tick();
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL held_high: got %h exp %h", dut_vec, model_vec()); end
      trigger = 0;
      pop_one();
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL single_pop: got %h exp %h", dut_vec, model_vec()); end
   endtask

   task automatic test_overflow();
      clear_all();
      for (int k = 0; k < 5; k++) begin
         do_edge(0, 0);
         checks++;
         if (dut_vec !== model_vec()) begin errs++; $display("FAIL fill_%0d: got %h exp %h", k, dut_vec, model_vec()); end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_vec !== model_vec()) begin errs++; $display("FAIL drain_%0d: got %h exp %h", k, dut_vec, model_vec()); end
         pop_one();
      end
      checks++;
      if (evt_valid !== 1'b0) begin errs++; $display("FAIL drained_empty: got %b exp 0", evt_valid); end
      pop_one();
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL pop_empty: got %h exp %h", dut_vec, model_vec()); end
   endtask

   task automatic test_back_to_back();
      clear_all();
      for (int k = 0; k < 4; k++) begin
         do_edge(0, 0);
         tick();
      end
      do_edge(1, 0);
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL full_pop_push: got %h exp %h", dut_vec, model_vec()); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (dut_vec !== model_vec()) begin errs++; $display("FAIL full_drain_%0d: got %h exp %h", k, dut_vec, model_vec()); end
         pop_one();
      end
      checks++;
      if (evt_valid !== 1'b0) begin errs++; $display("FAIL full_drained: got %b exp 0", evt_valid); end
   endtask

   task automatic test_saturate();
      clear_all();
      for (int k = 0; k < 300; k++) begin
         do_edge(1, 0);
         if (k == 0 || k == 299) begin
            checks++;
            if (dut_vec !== model_vec()) begin errs++; $display("FAIL sat_%0d: got %h exp %h", k, dut_vec, model_vec()); end
         end
         tick();
      end
      checks++;
      if (evt_count !== 8'd255) begin errs++; $display("FAIL sat_count: got %0d exp 255", evt_count); end
      do_edge(0, 1);
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL clr_edge: got %h exp %h", dut_vec, model_vec()); end
      tick();
      do_edge(0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL after_clr: got %h exp %h", dut_vec, model_vec()); end
   endtask

   task automatic test_wrap();
      clear_all();
      while (((cyc + LAT) % 16) != 1) tick();
      do_edge(0, 0);
      checks++;
      if (w_time !== 4'd1 || w_valid !== 1'b1) begin errs++; $display("FAIL wrap_time: got %0d/%b exp 1/1", w_time, w_valid); end
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL wrap_main: got %h exp %h", dut_vec, model_vec()); end
   endtask

   task automatic test_reset_mid();
      clear_all();
      for (int k = 0; k < 3; k++) begin
         do_edge(0, 0);
         tick();
      end
      checks++;
      if (dut_vec !== model_vec()) begin errs++; $display("FAIL queued3: got %h exp %h", dut_vec, model_vec()); end
      rst = 1;
      model_clear();
      #1;
      checks++;
      if (dut_vec !== 27'h0 || w_valid !== 1'b0) begin errs++; $display("FAIL async_rst: got %h exp 0", dut_vec); end
      @(posedge clk);
      #1;
      rst = 0;
      cyc = 0;
      tick();
      tick();
      checks++;
      if (dut_vec !== 27'h0) begin errs++; $display("FAIL post_rst: got %h exp 0", dut_vec); end
      do_edge(0, 0);
      checks++;
      if (evt_time !== 16'(2 + LAT) || dut_vec !== model_vec()) begin errs++; $display("FAIL rst_restart: got %h exp %h", dut_vec, model_vec()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_back_to_back();
      test_saturate();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/trig_mon.md
TRIG_MON -- requirements
Module: trig_mon

Interface
REQ-001 Parameter TS_W, default 16: timestamp and free-running cycle-counter width in bits.
REQ-002 Parameter DEPTH, default 4: event FIFO depth in entries, a power of two and at least 2.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port trigger, input, 1: trigger line from the upstream trigger-condition stage, monitored level.
REQ-006 Port clr, input, 1: synchronous clear of all event state.
REQ-007 Port rd_ready, input, 1: consumer accepts the head event.
REQ-008 Port evt_valid, output, 1: FIFO holds at least one event.
REQ-009 Port evt_time, output, TS_W: timestamp of the head event; valid only while evt_valid=1.
REQ-010 Port evt_count, output, 8: saturating count of trigger rising edges.
REQ-011 Port alarm, output, 1: sticky flag, set once any rising edge is detected.
REQ-012 Port overflow, output, 1: sticky flag, set when an edge is dropped because the FIFO is full.

Function
REQ-013 A TS_W-bit cycle counter shall increment every clock, wrap from all-ones to 0, and be unaffected by clr.
REQ-014 The block shall register the sampled trigger (trig_q). An edge is the cycle where the sampled trigger is 1 and trig_q is 0.
- A level held high produces exactly one edge.
- The first sample after reset is compared against trig_q=0.
REQ-015 On an edge in cycle N, the cycle-counter value of cycle N shall be pushed to the FIFO. evt_valid shall rise in cycle N+1 if the FIFO was empty.
REQ-016 Pop occurs when evt_valid=1 and rd_ready=1 at a clock edge. evt_time shall show the next entry in the following cycle.
REQ-017 The FIFO shall preserve order. evt_valid shall be a registered-state output: empty flag inverted, with no combinational path from rd_ready.
REQ-018 Push when full without a simultaneous pop:
- the event shall be dropped;
- overflow shall set in the next cycle;
- FIFO contents shall be unchanged.
REQ-019 Push when full with a simultaneous pop: both shall occur, occupancy shall stay DEPTH, and overflow shall not set.
REQ-020 Pop when empty shall have no effect.
REQ-021 evt_count shall increment by 1 per edge, including dropped edges, and saturate at 255.
REQ-022 alarm shall set in cycle N+1 after the first edge and hold until clr or rst.
REQ-023 When clr=1, the next clock edge shall do all of the following:
- empty the FIFO;
- zero evt_count;
- clear alarm and overflow;
- ignore any edge or pop in the same cycle.
trig_q shall still update during clr.

Reset
REQ-024 While rst=1, asynchronously:
- evt_valid=0, evt_time=0, evt_count=0, alarm=0, overflow=0;
- FIFO pointers, trig_q and the cycle counter = 0.
REQ-025 Reset asserted mid-operation shall discard all pending events immediately. The first clock after deassertion shall count as cycle 0.

Configuration
REQ-026 Macro TRIG_MON_SYNC_EN defined:
- trigger shall pass through a two-flop synchronizer before edge detection;
- edge-to-push latency grows by 2 cycles;
- the timestamp is the counter value when the synchronized edge is detected;
- the synchronizer flops reset to 0.
REQ-027 Macro TRIG_MON_SYNC_EN undefined: trigger shall be sampled directly and all timing is as in REQ-015.

Verification
REQ-028 rst released, trigger rises at cycle 5 and is held high, rd_ready=0 -> at cycle 6: evt_valid=1, evt_time=5, evt_count=1, alarm=1. No further events.
REQ-029 Five single-cycle pulses at cycles 10, 12, 14, 16, 18 with DEPTH=4, rd_ready=0 -> times 10, 12, 14, 16 retained, overflow=1 from cycle 19, evt_count=5. Then rd_ready=1 pops 10, 12, 14, 16 in order and evt_valid falls.
REQ-030 FIFO full, rd_ready=1 and a new edge at cycle 30 -> head popped, 30 appended, occupancy stays 4, overflow=0.
REQ-031 300 pulses with rd_ready=1 -> evt_count saturates at 255. A pulse coincident with clr=1 -> evt_count=0, evt_valid=0, alarm=0 next cycle.
REQ-032 TS_W=4, pulse at cycle 17 -> evt_time=1 (wrap). Build with TRIG_MON_SYNC_EN: pulse at cycle 5 -> evt_time=7, evt_valid rises at cycle 8.
REQ-033 rst asserted for 1 cycle with 3 events queued -> all outputs 0 immediately and the queue stays empty after release.
